scr1_dmem_ahb_q: RTL and testbench

SCR1_DMEM_AHB_Q -- requirements
Module: scr1_dmem_ahb_q

---
 rtl/scr1_dmem_ahb_q.sv | 212 +++++++++++++++++++++
 tb/tb_scr1_dmem_ahb_q.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_ahb_q.sv
// Queued bridge from the SCR1 core data-memory port to a single-beat AHB-Lite master.
// Optional macro SCR1_DMEM_AHB_RESP_REG_EN registers the response path toward the core.

package scr1_dmem_ahb_q_pkg;
  localparam int SCR1_AHB_WIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef struct packed {
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [SCR1_AHB_WIDTH-1:0] haddr;
    logic [SCR1_AHB_WIDTH-1:0] hwdata;
    logic                      misalign;
  } req_entry_t;
endpackage

module scr1_dmem_ahb_q
  import scr1_dmem_ahb_q_pkg::*;
#(
  parameter int REQ_DEPTH    = 2,
  parameter int MISALIGN_CHK = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      dmem_req_ack,
  input  logic                      dmem_req,
  input  type_scr1_mem_cmd_e        dmem_cmd,
  input  type_scr1_mem_width_e      dmem_width,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_wdata,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e       dmem_resp,
  output logic [3:0]                hprot,
  output logic [2:0]                hburst,
  output logic [2:0]                hsize,
  output logic [1:0]                htrans,
  output logic                      hmastlock,
  output logic [SCR1_AHB_WIDTH-1:0] haddr,
  output logic                      hwrite,
  output logic [SCR1_AHB_WIDTH-1:0] hwdata,
  input  logic                      hready,
  input  logic [SCR1_AHB_WIDTH-1:0] hrdata,
  input  logic                      hresp
);
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {FSM_ADDR, FSM_DATA} fsm_e;

  req_entry_t                mem_q [REQ_DEPTH];
  req_entry_t                new_entry, head;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  fsm_e                      fsm_q, fsm_d;
  logic [SCR1_AHB_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [1:0]                dp_size_q, dp_size_d, dp_lane_q, dp_lane_d;
  logic                      full, push, pop, issue, mis_pop, head_vld, dp_ok;
  logic                      resp_vld_d, resp_err_d;
  logic [SCR1_AHB_WIDTH-1:0] rdata_d, rd_shift_b, rd_shift_h;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Store data is steered onto its byte lanes at enqueue time.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    new_entry        = '0;
    new_entry.hwrite = (dmem_cmd == SCR1_MEM_CMD_WR);
    new_entry.haddr  = dmem_addr;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE: begin
        new_entry.hsize  = 3'b000;
        new_entry.hwdata = {24'h0, dmem_wdata[7:0]} << {dmem_addr[1:0], 3'b000};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        new_entry.hsize    = 3'b001;
        new_entry.hwdata   = {16'h0, dmem_wdata[15:0]} << {dmem_addr[1], 4'b0000};
        new_entry.misalign = dmem_addr[0];
      end
      default: begin
        new_entry.hsize    = 3'b010;
        new_entry.hwdata   = dmem_wdata;
        new_entry.misalign = |dmem_addr[1:0];
      end
    endcase
    if (MISALIGN_CHK == 0) new_entry.misalign = 1'b0;
  end

  always_comb begin
    full         = (cnt_q == CNT_W'(REQ_DEPTH));
    dmem_req_ack = ~full;
    push         = dmem_req & ~full;
    head_vld     = (cnt_q != '0);
    head         = mem_q[rd_ptr_q];
    dp_ok        = (fsm_q == FSM_DATA) & hready & ~hresp;
    issue        = head_vld & ~head.misalign & ((fsm_q == FSM_ADDR) | dp_ok);
    // Misaligned heads retire only with no data phase open, which keeps responses in order.
    mis_pop      = head_vld & head.misalign & (fsm_q == FSM_ADDR);
    pop          = issue | mis_pop;
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    hwdata_d     = issue ? head.hwdata      : hwdata_q;
    dp_size_d    = issue ? head.hsize[1:0]  : dp_size_q;
    dp_lane_d    = issue ? head.haddr[1:0]  : dp_lane_q;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_ADDR: if (issue)  fsm_d = FSM_DATA;
      FSM_DATA: if (hready) fsm_d = issue ? FSM_DATA : FSM_ADDR;
      default:              fsm_d = FSM_ADDR;
    endcase
  end

  always_comb begin
    resp_vld_d = ((fsm_q == FSM_DATA) & hready) | mis_pop;
    resp_err_d = ((fsm_q == FSM_DATA) & hresp)  | mis_pop;
    rd_shift_b = hrdata >> {dp_lane_q, 3'b000};
    rd_shift_h = hrdata >> {dp_lane_q[1], 4'b0000};
    case (dp_size_q)
      2'b00:   rdata_d = {24'h0, rd_shift_b[7:0]};
      2'b01:   rdata_d = {16'h0, rd_shift_h[15:0]};
      default: rdata_d = hrdata;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= FSM_ADDR;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: queue storage and data-phase registers are not reset; count and fsm gate every use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
    hwdata_q  <= hwdata_d;
    dp_size_q <= dp_size_d;
    dp_lane_q <= dp_lane_d;
  end

  logic resp_vld, resp_err;
`ifdef SCR1_DMEM_AHB_RESP_REG_EN
  logic                      resp_vld_q, resp_err_q;
  logic [SCR1_AHB_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      resp_vld_q <= resp_vld_d;
      resp_err_q <= resp_err_d;
    end
  end
  always_ff @(posedge clk) rdata_q <= rdata_d;
  assign resp_vld   = resp_vld_q;
  assign resp_err   = resp_err_q;
  assign dmem_rdata = rdata_q;
`else
  assign resp_vld   = resp_vld_d;
  assign resp_err   = resp_err_d;
  assign dmem_rdata = rdata_d;
`endif

  always_comb begin
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    if (resp_vld) begin
      if (resp_err) dmem_resp = SCR1_MEM_RESP_RDY_ER;
      else          dmem_resp = SCR1_MEM_RESP_RDY_OK;
    end
  end

  assign htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = head.haddr;
  assign hwrite    = head.hwrite;
  assign hsize     = head.hsize;
  assign hwdata    = hwdata_q;
  assign hprot     = 4'b0001;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;

endmodule

// File: tb/tb_scr1_dmem_ahb_q.sv
// Directed bench for scr1_dmem_ahb_q: core driver, AHB slave model and in-order scoreboards.
`timescale 1ns/1ps
module tb_scr1_dmem_ahb_q;
  import scr1_dmem_ahb_q_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;

  logic                 clk = 1'b0, rst_n = 1'b0;
  logic                 dmem_req_ack, dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic [3:0]           hprot;
  logic [2:0]           hburst, hsize;
  logic [1:0]           htrans;
  logic                 hmastlock, hwrite, hready, hresp;
  logic [31:0]          haddr, hwdata, hrdata;

  always #5 clk = ~clk;

  scr1_dmem_ahb_q #(.REQ_DEPTH(DEPTH), .MISALIGN_CHK(1)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_req_ack(dmem_req_ack), .dmem_req(dmem_req),
    .dmem_cmd(dmem_cmd), .dmem_width(dmem_width), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .hprot(hprot), .hburst(hburst), .hsize(hsize), .htrans(htrans),
    .hmastlock(hmastlock), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata; logic err; } ahb_exp_t;
  typedef struct { type_scr1_mem_resp_e resp; logic chk_data; logic [31:0] rdata; logic mis; } rsp_exp_t;

  ahb_exp_t ahb_exp[$];
  rsp_exp_t rsp_exp[$];
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave memory image: one preloaded word, a recognisable pattern elsewhere.
  function automatic logic [31:0] slv_word(input logic [31:0] a);
    if ({a[31:2], 2'b00} == 32'h0000_1000) return 32'h5A00_0000;
    return {~a[15:2], 2'b00, a[15:2], 2'b00};
  endfunction

  // AHB slave: data phase tracking, programmable wait states and two-cycle ERROR
  logic        dp_vld = 1'b0, dp_wr, dp_err;
  logic [31:0] dp_addr, dp_wdata_exp;
  int          dp_cyc = 0, stall_n = 0;
  logic        mon_err = 1'b0;
  logic [31:0] mon_wdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_vld <= 1'b0;
      dp_cyc <= 0;
    end else if (htrans == NONSEQ) begin
      dp_vld       <= 1'b1;
      dp_addr      <= haddr;
      dp_wr        <= hwrite;
      dp_err       <= mon_err;
      dp_wdata_exp <= mon_wdata;
      dp_cyc       <= 0;
    end else if (hready) begin
      dp_vld <= 1'b0;
    end else begin
      dp_cyc <= dp_cyc + 1;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (dp_vld) begin
      if (dp_err) begin
        hresp  = 1'b1;
        hready = (dp_cyc >= 1);
      end else begin
        hready = (dp_cyc >= stall_n);
      end
      if (!dp_wr) hrdata = slv_word(dp_addr);
    end
  end

  // Monitor on the falling edge: occupancy/ack model, AHB address phases, responses
  int       occ_acc = 0, occ_out = 0, run = 0, max_run = 0;
  logic     ack_low_seen = 1'b0, err_cyc_seen = 1'b0;
  ahb_exp_t me;
  rsp_exp_t mr;

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_vs_occupancy", 32'(dmem_req_ack), 32'((occ_acc - occ_out) != DEPTH));
      if (!dmem_req_ack) ack_low_seen = 1'b1;
      if (dp_vld && dp_err && !hready) begin
        err_cyc_seen = 1'b1;
        check("err_first_cycle_htrans", 32'(htrans), 32'(IDLE));
      end
      if (dp_vld && dp_wr) check("hwdata", hwdata, dp_wdata_exp);
      if (htrans == NONSEQ) begin
        run++;
        if (run > max_run) max_run = run;
        occ_out++;
        if (ahb_exp.size() == 0) begin
          check("unexpected_nonseq", 32'(htrans), 32'(IDLE));
        end else begin
          me = ahb_exp.pop_front();
          check("haddr", haddr, me.addr);
          check("hwrite", 32'(hwrite), 32'(me.wr));
          check("hsize", 32'(hsize), 32'(me.size));
          mon_err   = me.err;
          mon_wdata = me.wdata;
        end
      end else begin
        run = 0;
        check("htrans_idle", 32'(htrans), 32'(IDLE));
        if (dp_vld && !hready && ahb_exp.size() != 0 && (occ_acc - occ_out) > 0)
          check("haddr_stable", haddr, ahb_exp[0].addr);
      end
      if (dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
        if (rsp_exp.size() == 0) begin
          check("unexpected_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        end else begin
          mr = rsp_exp.pop_front();
          check("dmem_resp", 32'(dmem_resp), 32'(mr.resp));
          if (mr.chk_data) check("dmem_rdata", dmem_rdata, mr.rdata);
          if (mr.mis) occ_out++;
        end
      end
    end
  end

  // Core driver: holds the request until accepted, then records expectations
  task automatic push(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] d, input logic err);
    ahb_exp_t    e;
    rsp_exp_t    r;
    logic        mis;
    logic [31:0] wd, word, rd;
    int          n = 0;
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = d;
    @(negedge clk);
    while (!dmem_req_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dmem_req_ack) begin
      check("push_ack_timeout", 32'(dmem_req_ack), 32'd1);
      dmem_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    mis  = (w == SCR1_MEM_WIDTH_HWORD && a[0]) || (w == SCR1_MEM_WIDTH_WORD && a[1:0] != 2'b00);
    word = slv_word(a);
    case (w)
      SCR1_MEM_WIDTH_BYTE: begin
        case (a[1:0])
          2'd0: begin wd = {24'h0, d[7:0]};        rd = {24'h0, word[7:0]};   end
          2'd1: begin wd = {16'h0, d[7:0], 8'h0};  rd = {24'h0, word[15:8]};  end
          2'd2: begin wd = {8'h0, d[7:0], 16'h0};  rd = {24'h0, word[23:16]}; end
          default: begin wd = {d[7:0], 24'h0};     rd = {24'h0, word[31:24]}; end
        endcase
        e.size = 3'd0;
      end
      SCR1_MEM_WIDTH_HWORD: begin
        wd = a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]};
        rd = a[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
        e.size = 3'd1;
      end
      default: begin
        wd = d; rd = word; e.size = 3'd2;
      end
    endcase
    occ_acc++;
    r.mis = mis;
    if (mis) begin
      r.resp = SCR1_MEM_RESP_RDY_ER; r.chk_data = 1'b0; r.rdata = '0;
    end else begin
      e.addr = a; e.wr = (cmd == SCR1_MEM_CMD_WR); e.wdata = wd; e.err = err;
      ahb_exp.push_back(e);
      r.resp     = err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      r.chk_data = !err && (cmd == SCR1_MEM_CMD_RD);
      r.rdata    = rd;
    end
    rsp_exp.push_back(r);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dmem_req = 1'b0;
    while ((rsp_exp.size() != 0 || ahb_exp.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_pending_left"}, 32'(rsp_exp.size() + ahb_exp.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    dmem_req = 1'b0; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr = '0; dmem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_htrans", 32'(htrans), 32'(IDLE));
    check("rst_ack", 32'(dmem_req_ack), 32'd1);
    check("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("hprot", 32'(hprot), 32'h1);
    check("hburst", 32'(hburst), 32'h0);
    check("hmastlock", 32'(hmastlock), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four back-to-back word reads with a zero-wait slave
    stall_n = 0; max_run = 0; ack_low_seen = 1'b0;
    for (int i = 0; i < 4; i++) push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100 + 32'(4 * i), '0, 1'b0);
    drain("b2b_reads");
    check("b2b_consecutive_nonseq", 32'(max_run), 32'd4);
    check("b2b_ack_never_low", 32'(ack_low_seen), 32'd0);

    // Three wait states while the core keeps pushing word writes
    stall_n = 3; ack_low_seen = 1'b0;
    for (int i = 0; i < 6; i++) push(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
    drain("stall_writes");
    check("stall_ack_dropped", 32'(ack_low_seen), 32'd1);
    stall_n = 0;

    // Sub-word lane steering on writes and reads
    push(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h1003, 32'h0000_00A5, 1'b0);
    push(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h2002, 32'h0000_1234, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h1003, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h1002, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h3001, '0, 1'b0);
    drain("lanes");

    // Misaligned accesses retire locally, in order
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h3000, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h2002, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h3004, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h3001, '0, 1'b0);
    drain("misaligned");

    // Two-cycle slave ERROR with a second request queued
    err_cyc_seen = 1'b0;
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4000, '0, 1'b1);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4004, '0, 1'b0);
    drain("slave_error");
    check("error_first_cycle_seen", 32'(err_cyc_seen), 32'd1);

    // Reset during a stalled data phase with two requests queued
    stall_n = 10;
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h5000, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h5004, '0, 1'b0);
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h5008, '0, 1'b0);
    dmem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    ahb_exp.delete(); rsp_exp.delete();
    occ_acc = 0; occ_out = 0;
    @(posedge clk); #1;
    check("inrst_htrans", 32'(htrans), 32'(IDLE));
    check("inrst_ack", 32'(dmem_req_ack), 32'd1);
    check("inrst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    rst_n = 1'b1; stall_n = 0;
    @(negedge clk);
    check("postrst_htrans", 32'(htrans), 32'(IDLE));
    check("postrst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    @(posedge clk); #1;
    push(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h6000, '0, 1'b0);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
